// File: rtl/axi_tlp_encoder_pkg.sv
// axi_tlp_pkg: completion codes, TLP header constants and encoder state encoding
package axi_tlp_pkg;

    localparam logic [2:0] CODE_REG_RD = 3'b001;
    localparam logic [2:0] CODE_CFG_RD = 3'b010;
    localparam logic [2:0] CODE_CFG_WR = 3'b011;
    localparam logic [2:0] CODE_ADC_RD = 3'b100;

    localparam logic [6:0] FMT_TYPE_CPL  = 7'b00_01010;
    localparam logic [6:0] FMT_TYPE_CPLD = 7'b10_01010;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;
    localparam logic [2:0] CPL_CA = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT_DATA,
        ST_HDR,
        ST_DATA
    } tlp_state_e;

    function automatic logic is_valid_code(input logic [2:0] code);
        return code == CODE_REG_RD || code == CODE_CFG_RD || code == CODE_CFG_WR || code == CODE_ADC_RD;
    endfunction

endpackage

// File: rtl/axi_tlp_encoder_if.sv
// axi_tlp_encoder_if: 64-bit AXI4-Stream TX port toward the PCIe endpoint core
interface axi_tlp_encoder_if;
    logic        tx_tvalid;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tstrb;
    logic        tx_tlast;
    logic [3:0]  tx_tuser;
    logic        tx_tready;
    logic [5:0]  tx_buf_av;

    modport master (
        output tx_tvalid, tx_tdata, tx_tstrb, tx_tlast, tx_tuser,
        input  tx_tready, tx_buf_av
    );

    modport slave (
        input  tx_tvalid, tx_tdata, tx_tstrb, tx_tlast, tx_tuser,
        output tx_tready, tx_buf_av
    );
endinterface

// File: rtl/axi_tlp_encoder_be_calc.sv
// tlp_be_calc: maps the first byte-enable nibble to completion byte count and lower address bits
module tlp_be_calc (
    input  logic [3:0] first_be,
    output logic [2:0] byte_count,
    output logic [1:0] lo
);
    always_comb begin
        byte_count = (first_be[3] && first_be[0]) ? 3'd4 :
                     ((first_be[3:2] == 2'b01 && first_be[0]) || (first_be[3] && first_be[1:0] == 2'b10)) ? 3'd3 :
                     (first_be == 4'b0011 || first_be == 4'b0110 || first_be == 4'b1100) ? 3'd2 : 3'd1;
        lo = (first_be[0] || first_be == 4'b0000) ? 2'd0 :
             first_be[1] ? 2'd1 :
             first_be[2] ? 2'd2 : 2'd3;
    end
endmodule

// File: rtl/axi_tlp_encoder.sv
// axi_tlp_encoder: builds 3DW-header Cpl/CplD TLPs on the 64-bit AXIS TX port
// for non-posted requests handed over by the RX decoder.
module axi_tlp_encoder
    import axi_tlp_pkg::*;
#(
    parameter int AXIDATAWIDTH = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_compl,
    input  logic [2:0]  compl_code,
    input  logic [2:0]  tenc_tc,
    input  logic [1:0]  tenc_attr,
    input  logic [9:0]  tenc_len,
    input  logic [15:0] tenc_rid,
    input  logic [7:0]  tenc_tag,
    input  logic [7:0]  tenc_be,
    input  logic [12:0] tenc_addr,
    input  logic [15:0] cfg_completer_id,
    input  logic [31:0] a4lm_rd_data,
    input  logic        a4lm_rd_valid,
    input  logic [31:0] cfg_rd_data,
    input  logic        cfg_rd_valid,
    input  logic [31:0] adc_rd_data,
    input  logic        adc_rd_valid,
    output logic        tlp_enc_ready,
    axi_tlp_encoder_if.master tx
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [7:0] STRB_ALL = 8'((1 << AXIDATAWIDTH) - 1);

    tlp_state_e  state;
    logic [2:0]  code;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [3:0]  first_be;
    logic [4:0]  addr_lo;
    logic [15:0] cpl_id;
    logic [2:0]  status;
    logic        with_data;
    logic [31:0] rd_data;
    logic [CW-1:0] cnt;
    logic        valid_q;

    logic        strobe;
    logic [31:0] sel_data;
    logic [2:0]  be_count;
    logic [1:0]  lo;
    logic [11:0] byte_count;
    logic [31:0] hdr0;
    logic [31:0] hdr1;
    logic [63:0] beat1;
    logic        unused_bits;

    assign unused_bits = ^{tenc_be[7:4], tenc_addr[12:5]};

    tlp_be_calc u_be_calc (
        .first_be   (first_be),
        .byte_count (be_count),
        .lo         (lo)
    );

    // Only the source addressed by the latched code may complete the wait
    always_comb begin
        strobe   = code == CODE_REG_RD ? a4lm_rd_valid :
                   code == CODE_CFG_RD ? cfg_rd_valid :
                   code == CODE_ADC_RD ? adc_rd_valid : 1'b0;
        sel_data = code == CODE_REG_RD ? a4lm_rd_data :
                   code == CODE_CFG_RD ? cfg_rd_data : adc_rd_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            code      <= '0;
            tc        <= '0;
            attr      <= '0;
            len       <= '0;
            rid       <= '0;
            tag       <= '0;
            first_be  <= '0;
            addr_lo   <= '0;
            cpl_id    <= '0;
            status    <= CPL_SC;
            with_data <= 1'b0;
            rd_data   <= '0;
            cnt       <= '0;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req_compl && is_valid_code(compl_code)) begin
                    code     <= compl_code;
                    tc       <= tenc_tc;
                    attr     <= tenc_attr;
                    len      <= tenc_len;
                    rid      <= tenc_rid;
                    tag      <= tenc_tag;
                    first_be <= tenc_be[3:0];
                    state    <= ST_ADDR;
                end
                ST_ADDR: begin
                    addr_lo   <= tenc_addr[4:0];
                    cpl_id    <= cfg_completer_id;
                    cnt       <= '0;
                    with_data <= 1'b0;
                    if (code == CODE_CFG_WR || len != 10'd1) begin
                        status  <= code == CODE_CFG_WR ? CPL_SC : CPL_UR;
                        valid_q <= |tx.tx_buf_av;
                        state   <= ST_HDR;
                    end else begin
                        state <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    cnt <= cnt + 1'b1;
                    // data arriving on the timeout cycle still wins
                    if (strobe) begin
                        rd_data   <= sel_data;
                        with_data <= 1'b1;
                        status    <= CPL_SC;
                        valid_q   <= |tx.tx_buf_av;
                        state     <= ST_HDR;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        status  <= CPL_CA;
                        valid_q <= |tx.tx_buf_av;
                        state   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!valid_q) valid_q <= |tx.tx_buf_av;
                    else if (tx.tx_tready) state <= ST_DATA;
                end
                ST_DATA: if (tx.tx_tready) begin
                    valid_q <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_count = with_data ? {9'b0, be_count} : 12'd4;
        hdr0  = {1'b0, with_data ? FMT_TYPE_CPLD : FMT_TYPE_CPL, 1'b0, tc, 4'b0, 1'b0, 1'b0,
                 attr, 2'b0, with_data ? 10'd1 : 10'd0};
        hdr1  = {cpl_id, status, 1'b0, byte_count};
        beat1 = {with_data ? rd_data : 32'h0, rid, tag, 1'b0, addr_lo, lo};
    end

    assign tlp_enc_ready = state == ST_IDLE;
    assign tx.tx_tvalid  = valid_q;
    assign tx.tx_tdata   = state == ST_HDR ? {hdr1, hdr0} : state == ST_DATA ? beat1 : 64'h0;
    assign tx.tx_tstrb   = state == ST_HDR ? STRB_ALL :
                           state == ST_DATA ? (with_data ? STRB_ALL : 8'h0F) : 8'h00;
    assign tx.tx_tlast   = state == ST_DATA;
    assign tx.tx_tuser   = 4'h0;

endmodule

// File: tb/tb_axi_tlp_encoder.sv
// tb_axi_tlp_encoder: randomized completion traffic checked against a TLP-level reference model
module tb_axi_tlp_encoder;
    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_compl = 1'b0;
    logic [2:0]  compl_code = '0;
    logic [2:0]  tenc_tc = '0;
    logic [1:0]  tenc_attr = '0;
    logic [9:0]  tenc_len = '0;
    logic [15:0] tenc_rid = '0;
    logic [7:0]  tenc_tag = '0;
    logic [7:0]  tenc_be = '0;
    logic [12:0] tenc_addr = '0;
    logic [15:0] cfg_completer_id = '0;
    logic [31:0] a4lm_rd_data = '0;
    logic        a4lm_rd_valid = 1'b0;
    logic [31:0] cfg_rd_data = '0;
    logic        cfg_rd_valid = 1'b0;
    logic [31:0] adc_rd_data = '0;
    logic        adc_rd_valid = 1'b0;
    logic        tlp_enc_ready;

    axi_tlp_encoder_if tx_if ();

    axi_tlp_encoder #(.AXIDATAWIDTH(8), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_compl        (req_compl),
        .compl_code       (compl_code),
        .tenc_tc          (tenc_tc),
        .tenc_attr        (tenc_attr),
        .tenc_len         (tenc_len),
        .tenc_rid         (tenc_rid),
        .tenc_tag         (tenc_tag),
        .tenc_be          (tenc_be),
        .tenc_addr        (tenc_addr),
        .cfg_completer_id (cfg_completer_id),
        .a4lm_rd_data     (a4lm_rd_data),
        .a4lm_rd_valid    (a4lm_rd_valid),
        .cfg_rd_data      (cfg_rd_data),
        .cfg_rd_valid     (cfg_rd_valid),
        .adc_rd_data      (adc_rd_data),
        .adc_rd_valid     (adc_rd_valid),
        .tlp_enc_ready    (tlp_enc_ready),
        .tx               (tx_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // byte count spans lowest to highest enabled byte; an empty mask counts as one byte
    function automatic int bc_of(input logic [3:0] b);
        int lo_i = -1;
        int hi_i = -1;
        for (int i = 0; i < 4; i++) if (b[i]) begin
            if (lo_i < 0) lo_i = i;
            hi_i = i;
        end
        return lo_i < 0 ? 1 : hi_i - lo_i + 1;
    endfunction

    function automatic int lo_of(input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) return i;
        return 0;
    endfunction

    task automatic set_strobe(input logic [2:0] code, input logic [31:0] v);
        case (code)
            3'b001: begin a4lm_rd_valid = 1'b1; a4lm_rd_data = v; end
            3'b010: begin cfg_rd_valid = 1'b1; cfg_rd_data = v; end
            3'b100: begin adc_rd_valid = 1'b1; adc_rd_data = v; end
            default: ;
        endcase
    endtask

    function automatic logic [2:0] other_src(input logic [2:0] code);
        return code == 3'b001 ? 3'b010 : code == 3'b010 ? 3'b100 : code == 3'b100 ? 3'b001 : 3'b000;
    endfunction

    // d: cycles into the wait before the selected strobe (<0 never); bp: stall cycles per beat;
    // hold: cycles with tx_buf_av=0; abort: assert reset when the data beat appears
    task automatic run_txn(input logic [2:0] code, input logic [9:0] len, input logic [7:0] be,
                           input logic [12:0] addr, input logic [15:0] rid, input logic [7:0] tag,
                           input logic [2:0] tc, input logic [1:0] attr, input logic [31:0] data,
                           input int d, input int bp, input int hold, input bit abort);
        logic [63:0] exp_b [2];
        logic [7:0]  exp_s [2];
        logic [15:0] cid;
        logic [2:0]  st;
        bit          cpld;
        bit          seen;
        int          first, bc, k, bi, stall;
        cid  = 16'($urandom);
        cpld = 1'b0;
        st   = 3'b000;
        bc   = 4;
        if (code == 3'b011) first = 2;
        else if (len != 10'd1) begin first = 2; st = 3'b001; end
        else if (d >= 0 && d <= TO - 1) begin first = 3 + d; cpld = 1'b1; bc = bc_of(be[3:0]); end
        else begin first = 2 + TO; st = 3'b100; end
        if (hold + 1 > first) first = hold + 1;
        exp_b[0] = {cid, st, 1'b0, 12'(bc), 1'b0, cpld ? 2'b10 : 2'b00, 5'b01010, 1'b0, tc, 4'b0,
                    2'b0, attr, 2'b0, cpld ? 10'd1 : 10'd0};
        exp_b[1] = {cpld ? data : 32'h0, rid, tag, 1'b0, addr[4:0], 2'(lo_of(be[3:0]))};
        exp_s[0] = 8'hFF;
        exp_s[1] = cpld ? 8'hFF : 8'h0F;
        check("ready_before_req", 64'(tlp_enc_ready), 64'd1);
        cfg_completer_id = cid;
        tx_if.tx_buf_av = hold > 0 ? 6'd0 : 6'd8;
        tx_if.tx_tready = 1'b0;
        compl_code = code; tenc_len = len; tenc_be = be; tenc_rid = rid; tenc_tag = tag;
        tenc_tc = tc; tenc_attr = attr; tenc_addr = ~addr;
        req_compl = 1'b1;
        k = 0; bi = 0; stall = 0; seen = 1'b0;
        while (bi < 2 && k < first + 2 * bp + 20) begin
            @(negedge clk);
            k++;
            if (tx_if.tx_tvalid) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("first_valid_cycle", 64'(k), 64'(first));
                end
                check($sformatf("beat%0d_tdata", bi), tx_if.tx_tdata, exp_b[bi]);
                check($sformatf("beat%0d_tstrb", bi), 64'(tx_if.tx_tstrb), 64'(exp_s[bi]));
                check($sformatf("beat%0d_tlast", bi), 64'(tx_if.tx_tlast), 64'(bi == 1));
                check("tuser", 64'(tx_if.tx_tuser), 64'd0);
                check("busy_ready", 64'(tlp_enc_ready), 64'd0);
                if (abort && bi == 1) begin
                    reset = 1'b0;
                    #1;
                    check("abort_tvalid", 64'(tx_if.tx_tvalid), 64'd0);
                    check("abort_ready", 64'(tlp_enc_ready), 64'd1);
                    @(negedge clk);
                    reset = 1'b1;
                    a4lm_rd_valid = 1'b0; cfg_rd_valid = 1'b0; adc_rd_valid = 1'b0;
                    tx_if.tx_tready = 1'b0;
                    return;
                end
                if (stall < bp) begin
                    tx_if.tx_tready = 1'b0;
                    stall++;
                end else begin
                    tx_if.tx_tready = 1'b1;
                    stall = 0;
                    bi++;
                end
            end else begin
                tx_if.tx_tready = 1'($urandom_range(0, 1));
            end
            req_compl = 1'b0;
            tenc_addr = k == 1 ? addr : 13'($urandom);
            if (k == 1) begin
                tenc_rid = 16'($urandom); tenc_tag = 8'($urandom); tenc_be = 8'($urandom);
                tenc_len = 10'($urandom); tenc_tc = 3'($urandom); tenc_attr = 2'($urandom);
            end
            if (hold > 0 && k == hold) tx_if.tx_buf_av = 6'd8;
            a4lm_rd_valid = 1'b0; cfg_rd_valid = 1'b0; adc_rd_valid = 1'b0;
            if (code != 3'b011) begin
                if (k == 1) set_strobe(code, ~data);
                if (k == 2 + d) set_strobe(code, data);
                if (k == 2) set_strobe(other_src(code), ~data);
            end
        end
        check("handshakes", 64'(bi), 64'd2);
        @(negedge clk);
        tx_if.tx_tready = 1'b0;
        a4lm_rd_valid = 1'b0; cfg_rd_valid = 1'b0; adc_rd_valid = 1'b0;
        check("after_tvalid", 64'(tx_if.tx_tvalid), 64'd0);
        check("after_ready", 64'(tlp_enc_ready), 64'd1);
    endtask

    initial begin
        logic [2:0] codes [4];
        logic [2:0] bad [4];
        codes[0] = 3'b001; codes[1] = 3'b010; codes[2] = 3'b011; codes[3] = 3'b100;
        bad[0] = 3'b000; bad[1] = 3'b101; bad[2] = 3'b110; bad[3] = 3'b111;
        tx_if.tx_tready = 1'b0;
        tx_if.tx_buf_av = 6'd8;
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(tx_if.tx_tvalid), 64'd0);
        check("rst_tdata", tx_if.tx_tdata, 64'd0);
        check("rst_tstrb", 64'(tx_if.tx_tstrb), 64'd0);
        check("rst_tlast", 64'(tx_if.tx_tlast), 64'd0);
        check("rst_tuser", 64'(tx_if.tx_tuser), 64'd0);
        check("rst_ready", 64'(tlp_enc_ready), 64'd1);
        reset = 1'b1;
        @(negedge clk);

        run_txn(3'b001, 10'd1, 8'h0F, 13'h005, 16'h0100, 8'h07, 3'd0, 2'd0, 32'hDEADBEEF, 1, 0, 0, 1'b0);
        run_txn(3'b011, 10'd1, 8'h0F, 13'h010, 16'h0200, 8'h11, 3'd2, 2'd1, 32'h0, -1, 0, 0, 1'b0);
        run_txn(3'b010, 10'd1, 8'h0F, 13'h0A3, 16'h1234, 8'h22, 3'd7, 2'd3, 32'h600DF00D, 0, 5, 0, 1'b0);
        run_txn(3'b100, 10'd1, 8'hF0, 13'h004, 16'h0300, 8'h33, 3'd1, 2'd2, 32'h1, -1, 0, 0, 1'b0);
        run_txn(3'b100, 10'd1, 8'h0C, 13'h01F, 16'h0400, 8'h44, 3'd0, 2'd0, 32'hCAFE0001, TO - 1, 0, 0, 1'b0);
        run_txn(3'b001, 10'd2, 8'h06, 13'h008, 16'h0500, 8'h55, 3'd3, 2'd0, 32'h2, 0, 0, 0, 1'b0);
        run_txn(3'b010, 10'd1, 8'h06, 13'h008, 16'h0600, 8'h66, 3'd0, 2'd0, 32'hA5A5A5A5, 3, 0, 0, 1'b0);
        run_txn(3'b011, 10'd1, 8'h08, 13'h002, 16'h0700, 8'h77, 3'd0, 2'd0, 32'h0, -1, 1, 5, 1'b0);
        run_txn(3'b001, 10'd1, 8'h0F, 13'h006, 16'h0800, 8'h88, 3'd0, 2'd0, 32'h12345678, 0, 2, 0, 1'b1);
        run_txn(3'b001, 10'd1, 8'h03, 13'h007, 16'h0900, 8'h99, 3'd4, 2'd1, 32'h87654321, 2, 0, 0, 1'b0);

        foreach (bad[i]) begin
            compl_code = bad[i];
            req_compl = 1'b1;
            @(negedge clk);
            req_compl = 1'b0;
            repeat (3) @(negedge clk);
            check($sformatf("bad_code%0d_ready", bad[i]), 64'(tlp_enc_ready), 64'd1);
            check($sformatf("bad_code%0d_tvalid", bad[i]), 64'(tx_if.tx_tvalid), 64'd0);
        end

        for (int n = 0; n < 30; n++) begin
            logic [2:0] c;
            logic [9:0] l;
            int dd;
            c  = codes[$urandom_range(0, 3)];
            l  = $urandom_range(0, 3) == 0 ? 10'($urandom) : 10'd1;
            dd = $urandom_range(0, 7) == 0 ? -1 : int'($urandom_range(0, 5));
            run_txn(c, l, 8'($urandom), 13'($urandom), 16'($urandom), 8'($urandom), 3'($urandom),
                    2'($urandom), $urandom, dd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
